instr_mem_loader: RTL and testbench

//   Parametrised, synchronous instruction memory for the mini-CPU fetch stage; replaces the hard-coded

---
 rtl/instr_mem_loader_pkg.sv | 22 ++
 rtl/instr_mem_loader_word_assembler.sv | 41 ++++
 rtl/instr_mem_loader.sv | 143 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory and its byte-serial program loader.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package instr_mem_loader_pkg;

   // Loader FSM encoding, 2 bits.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // All-zero NOP; the CPU top level passes this as the out-of-range fetch word.
   localparam logic [27:0] NOP_WORD = 28'h0000000;

   // Number of download bytes needed to fill one instruction word.
   function automatic int bytes_per_word(input int data_w);
      return (data_w + 7) / 8;
   endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Shifts download bytes into one instruction word, first byte most significant.
// Latency: word updates on the accepting edge; word_rdy is combinational with the last byte.
// Backpressure: none; byte_vld must already be qualified by the loader's ready.
//
// Ports: clk, rst_n; clr restarts the byte count; byte_vld/byte_dat is an accepted byte;
//        word is the assembled word; word_rdy flags the byte that completes the word.
module instr_mem_loader_word_assembler #(
   parameter int DATA_W = 28,
   parameter int BPW    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              byte_vld,
   input  logic [7:0]        byte_dat,
   output logic [DATA_W-1:0] word,
   output logic              word_rdy
);

   localparam int               IDX_W    = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [IDX_W-1:0] idx;

   assign word_rdy = byte_vld && (idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx  <= '0;
         word <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (byte_vld) begin
         // High bits of the first byte fall off the top once the word is full.
         word <= {word[DATA_W-9:0], byte_dat};
         idx  <= word_rdy ? '0 : idx + IDX_ONE;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Synchronous instruction memory with a byte-serial run-time program loader.
// Latency: fetch 1 cycle; one word written per BPW+1 cycles with back-to-back bytes.
// Backpressure: load_byte_rdy only in LOAD; fetches are dropped (instr_vld=0) while busy.
//
// Ports: clk, rst_n (async, active low);
//        fetch/addr -> instr/instr_vld (registered), busy (loader not idle);
//        load_start/load_count start a download; load_byte_dat/load_byte_vld/load_byte_rdy
//        carry the bytes; load_done and load_error are single-cycle status pulses.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int                DATA_W       = 28,
   parameter int                ADDR_W       = 16,
   parameter int                DEPTH        = 256,
   parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(NOP_WORD)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] instr,
   output logic              instr_vld,
   output logic              busy,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_count,
   input  logic [7:0]        load_byte_dat,
   input  logic              load_byte_vld,
   output logic              load_byte_rdy,
   output logic              load_done,
   output logic              load_error
);

   localparam int                BPW     = bytes_per_word(DATA_W);
   localparam int                MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_W is representable in the range checks.
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state, state_n;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic [ADDR_W-1:0] count, count_n;
   logic              error_n;
   logic              asm_clr;
   logic              mem_we;
   logic              byte_accept;
   logic [DATA_W-1:0] word;
   logic              word_rdy;
   logic              fetch_ok;

   assign busy          = (state != ST_IDLE);
   assign load_byte_rdy = (state == ST_LOAD);
   assign load_done     = (state == ST_DONE);
   assign byte_accept   = load_byte_rdy && load_byte_vld;
   assign fetch_ok      = fetch && (state == ST_IDLE);

   instr_mem_loader_word_assembler #(
      .DATA_W (DATA_W),
      .BPW    (BPW)
   ) u_word_assembler (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (asm_clr),
      .byte_vld (byte_accept),
      .byte_dat (load_byte_dat),
      .word     (word),
      .word_rdy (word_rdy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         count      <= '0;
         load_error <= 1'b0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         count      <= count_n;
         load_error <= error_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      count_n = count;
      error_n = 1'b0;
      asm_clr = 1'b0;
      mem_we  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load_start) begin
               if ((load_count == '0) || ({1'b0, load_count} > DEPTH_X)) begin
                  error_n = 1'b1;
               end else begin
                  count_n = load_count;
                  ptr_n   = '0;
                  asm_clr = 1'b1;
                  state_n = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (word_rdy) state_n = ST_WRITE;
         end
         ST_WRITE: begin
            mem_we = 1'b1;
            if (ptr == count - ONE) begin
               state_n = ST_DONE;
            end else begin
               ptr_n   = ptr + ONE;
               state_n = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Memory contents survive reset so a reset mid-load keeps the words already written.
   always_ff @(posedge clk) begin
      if (mem_we) mem[ptr[MEM_AW-1:0]] <= word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr     <= DEFAULT_WORD;
         instr_vld <= 1'b0;
      end else begin
         instr_vld <= fetch_ok;
         if (fetch_ok) begin
            instr <= ({1'b0, addr} < DEPTH_X) ? mem[addr[MEM_AW-1:0]] : DEFAULT_WORD;
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: loads, fetches, rejected loads, range, stall, reset.
// Latency: n/a.
// Backpressure: byte driver honours load_byte_rdy.
module tb_instr_mem_loader;

   localparam int DATA_W = 28;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 256;

   logic              clk;
   logic              rst_n;
   logic              fetch;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] instr;
   logic              instr_vld;
   logic              busy;
   logic              load_start;
   logic [ADDR_W-1:0] load_count;
   logic [7:0]        load_byte_dat;
   logic              load_byte_vld;
   logic              load_byte_rdy;
   logic              load_done;
   logic              load_error;

   instr_mem_loader #(
      .DATA_W       (DATA_W),
      .ADDR_W       (ADDR_W),
      .DEPTH        (DEPTH),
      .DEFAULT_WORD (28'h0000000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch         (fetch),
      .addr          (addr),
      .instr         (instr),
      .instr_vld     (instr_vld),
      .busy          (busy),
      .load_start    (load_start),
      .load_count    (load_count),
      .load_byte_dat (load_byte_dat),
      .load_byte_vld (load_byte_vld),
      .load_byte_rdy (load_byte_rdy),
      .load_done     (load_done),
      .load_error    (load_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int viol  = 0;
   bit mon_en = 1'b0;
   time t0;

   logic [7:0] prog1 [12] = '{8'h0F, 8'h11, 8'h22, 8'h33,
                              8'h0A, 8'hBB, 8'hCC, 8'hDD,
                              8'h00, 8'h00, 8'h00, 8'h07};
   logic [7:0] prog2 [8]  = '{8'h01, 8'h02, 8'h03, 8'h04,
                              8'h05, 8'h06, 8'h07, 8'h08};
   logic [7:0] prog3 [6]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Counts cycles where a fetch result appears while the loader is busy.
   task automatic mon();
      if (mon_en && busy && instr_vld) viol++;
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall);
      int n = 0;
      if (stall > 0) begin
         load_byte_vld = 1'b0;
         repeat (stall) begin
            @(negedge clk);
            mon();
         end
      end
      load_byte_dat = b;
      load_byte_vld = 1'b1;
      while (!load_byte_rdy) begin
         @(negedge clk);
         mon();
         n++;
         if (n > 100) begin
            chk("byte_timeout", 32'd0, 32'd1);
            return;
         end
      end
      @(negedge clk);
      mon();
   endtask

   task automatic start_load(input logic [ADDR_W-1:0] cnt);
      load_count = cnt;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   // Returns at the negedge where load_done is high (or after the bound expires).
   task automatic wait_done();
      int n = 0;
      bit seen = 1'b0;
      while (n < 100) begin
         if (load_done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         mon();
         n++;
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic do_fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                           input string tag);
      fetch = 1'b1;
      addr  = a;
      @(negedge clk);
      fetch = 1'b0;
      chk({tag, "_vld"}, 32'(instr_vld), 32'd1);
      chk(tag, 32'(instr), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      fetch         = 1'b0;
      addr          = '0;
      load_start    = 1'b0;
      load_count    = '0;
      load_byte_dat = '0;
      load_byte_vld = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_vld", 32'(instr_vld), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdy", 32'(load_byte_rdy), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_err", 32'(load_error), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: three-word load, back-to-back bytes, then fetch back
      start_load(16'd3);
      t0 = $time;
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_rdy", 32'(load_byte_rdy), 32'd1);
      for (int i = 0; i < 12; i++) send_byte(prog1[i], 0);
      load_byte_vld = 1'b0;
      wait_done();
      chk("t1_cycles", 32'(($time - t0) / 10), 32'd15);
      @(negedge clk);
      chk("t1_done_1cyc", 32'(load_done), 32'd0);
      chk("t1_idle", 32'(busy), 32'd0);
      do_fetch(16'd0, 28'hF112233, "t1_w0");
      do_fetch(16'd1, 28'hABBCCDD, "t1_w1");
      do_fetch(16'd2, 28'h0000007, "t1_w2");
      @(negedge clk);
      chk("t1_vld_drop", 32'(instr_vld), 32'd0);
      chk("t1_hold", 32'(instr), 32'h0000007);

      // 2: rejected loads
      start_load(16'd0);
      chk("t2_err0", 32'(load_error), 32'd1);
      chk("t2_busy0", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t2_err0_1cyc", 32'(load_error), 32'd0);
      start_load(16'd257);
      chk("t2_err257", 32'(load_error), 32'd1);
      chk("t2_busy257", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t2_err257_1cyc", 32'(load_error), 32'd0);
      do_fetch(16'd2, 28'h0000007, "t2_mem");

      // 3: out-of-range fetches
      do_fetch(16'd256, 28'h0000000, "t3_depth");
      do_fetch(16'hFFFF, 28'h0000000, "t3_ffff");

      // 4: fetch held through a two-word load; same-cycle fetch is still served
      fetch = 1'b1;
      addr  = 16'd1;
      start_load(16'd2);
      chk("t4_first_vld", 32'(instr_vld), 32'd1);
      chk("t4_first_instr", 32'(instr), 32'hABBCCDD);
      viol   = 0;
      mon_en = 1'b1;
      for (int i = 0; i < 8; i++) send_byte(prog2[i], 0);
      load_byte_vld = 1'b0;
      wait_done();
      mon_en = 1'b0;
      chk("t4_done_vld", 32'(instr_vld), 32'd0);
      @(negedge clk);
      chk("t4_done_1cyc", 32'(load_done), 32'd0);
      chk("t4_idle_vld", 32'(instr_vld), 32'd0);
      @(negedge clk);
      chk("t4_resume_vld", 32'(instr_vld), 32'd1);
      chk("t4_resume_instr", 32'(instr), 32'h5060708);
      fetch = 1'b0;
      chk("t4_busy_viol", 32'(viol), 32'd0);
      do_fetch(16'd0, 28'h1020304, "t4_w0");

      // 5: asynchronous reset after six bytes of a two-word load
      start_load(16'd2);
      for (int i = 0; i < 6; i++) send_byte(prog3[i], 0);
      load_byte_vld = 1'b0;
      chk("t5_pre_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_rdy", 32'(load_byte_rdy), 32'd0);
      chk("t5_instr", 32'(instr), 32'd0);
      chk("t5_done", 32'(load_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_no_done", 32'(load_done), 32'd0);
      do_fetch(16'd0, 28'hABBCCDD, "t5_w0");
      do_fetch(16'd1, 28'h5060708, "t5_w1");

      // 6: stalled bytes plus an ignored mid-load start
      start_load(16'd3);
      for (int i = 0; i < 12; i++) begin
         if (i == 5) begin
            load_byte_vld = 1'b0;
            start_load(16'd1);
            chk("t6_mid_busy", 32'(busy), 32'd1);
            chk("t6_mid_err", 32'(load_error), 32'd0);
         end
         send_byte(prog1[i], int'($urandom_range(0, 3)));
      end
      load_byte_vld = 1'b0;
      wait_done();
      @(negedge clk);
      do_fetch(16'd0, 28'hF112233, "t6_w0");
      do_fetch(16'd1, 28'hABBCCDD, "t6_w1");
      do_fetch(16'd2, 28'h0000007, "t6_w2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
